// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm : Moore control FSM for a multi-cycle ARM-style DP datapath.
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [3:0]  NZCV,
  output logic        Write_PC,
  output logic        Write_IR,
  output logic        Write_Reg,
  output logic        L_A,
  output logic        L_B,
  output logic        L_C,
  output logic        L_F,
  output logic [1:0]  rm_imm_s,
  output logic [2:0]  rs_imm_s,
  output logic [3:0]  ALU_OP,
  output logic [2:0]  SHIFT_OP,
  output logic        S,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_alu_op;
  logic [2:0]  r_shift_op;
  logic [1:0]  r_rm_imm_s;
  logic [2:0]  r_rs_imm_s;

  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ok;
  logic        w_is_cmp;
  logic        w_valid_dp;
  logic [1:0]  w_rm_sel;
  logic [2:0]  w_rs_sel;
  logic [2:0]  w_sh_sel;
  logic        w_unused_ir;

  assign {w_n, w_z, w_c, w_v} = NZCV;
  assign w_unused_ir = ^{IR[19:8], IR[3:0]};

  always_comb begin
    w_cond_ok = 1'b0;
    case (IR[31:28])
      4'd0:  w_cond_ok = w_z;
      4'd1:  w_cond_ok = ~w_z;
      4'd2:  w_cond_ok = w_c;
      4'd3:  w_cond_ok = ~w_c;
      4'd4:  w_cond_ok = w_n;
      4'd5:  w_cond_ok = ~w_n;
      4'd6:  w_cond_ok = w_v;
      4'd7:  w_cond_ok = ~w_v;
      4'd8:  w_cond_ok = w_c & ~w_z;
      4'd9:  w_cond_ok = ~w_c | w_z;
      4'd10: w_cond_ok = (w_n == w_v);
      4'd11: w_cond_ok = (w_n != w_v);
      4'd12: w_cond_ok = ~w_z & (w_n == w_v);
      4'd13: w_cond_ok = w_z | (w_n != w_v);
      4'd14: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Opcodes 1000-1011 are the compare group: legal only with S set.
  assign w_is_cmp   = (IR[24:23] == 2'b10);
  assign w_valid_dp = (IR[27:26] == 2'b00) &&
                      (IR[25] || !IR[4] || !IR[7]) &&
                      (!w_is_cmp || IR[20]);

  assign w_rm_sel = IR[25] ? 2'b01 : 2'b00;
  assign w_rs_sel = IR[25] ? 3'b010 : (IR[4] ? 3'b001 : 3'b000);
  assign w_sh_sel = IR[25] ? 3'b111 : {IR[6:5], IR[4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_alu_op   <= 4'd0;
      r_shift_op <= 3'd0;
      r_rm_imm_s <= 2'd0;
      r_rs_imm_s <= 3'd0;
    end else begin
      r_state <= w_next;
      if (r_state == EXEC) begin
        r_alu_op   <= IR[24:21];
        r_shift_op <= w_sh_sel;
        r_rm_imm_s <= w_rm_sel;
        r_rs_imm_s <= w_rs_sel;
      end
    end
  end

  always_comb begin
    w_next    = IDLE;
    Write_PC  = 1'b0;
    Write_IR  = 1'b0;
    Write_Reg = 1'b0;
    L_A       = 1'b0;
    L_B       = 1'b0;
    L_C       = 1'b0;
    L_F       = 1'b0;
    rm_imm_s  = 2'd0;
    rs_imm_s  = 3'd0;
    ALU_OP    = 4'd0;
    SHIFT_OP  = 3'd0;
    S         = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        Write_PC = 1'b1;
        Write_IR = 1'b1;
        w_next   = DECODE;
      end
      DECODE: begin
        L_A    = 1'b1;
        L_B    = 1'b1;
        L_C    = 1'b1;
        w_next = (w_cond_ok && w_valid_dp) ? EXEC : FETCH;
      end
      EXEC: begin
        L_F      = 1'b1;
        ALU_OP   = IR[24:21];
        S        = IR[20];
        rm_imm_s = w_rm_sel;
        rs_imm_s = w_rs_sel;
        SHIFT_OP = w_sh_sel;
        w_next   = w_is_cmp ? FETCH : WB;
      end
      WB: begin
        Write_Reg = 1'b1;
        ALU_OP    = r_alu_op;
        SHIFT_OP  = r_shift_op;
        rm_imm_s  = r_rm_imm_s;
        rs_imm_s  = r_rs_imm_s;
        w_next    = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire
